// File: rtl/gpio_bank_if.sv
// Peripheral bus bundle between the SoC bus master and gpio_bank.
// The request is held until ready; ready is a one-cycle response strobe.
interface gpio_bank_if #(
  parameter int WIDTH = 3
);
  logic             valid;
  logic             write;
  logic [2:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic             ready;
  logic [WIDTH-1:0] rdata;

  modport master (output valid, write, addr, wdata, input ready, rdata);
  modport slave  (input valid, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: OUT/OE registers, synchronised and debounced inputs,
// and W1C edge-pending register that drives a level interrupt.
module gpio_bank #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic             io_clock,
  input  logic             io_resetn,
  input  logic [WIDTH-1:0] io_pins_read,
  output logic [WIDTH-1:0] io_pins_write,
  output logic [WIDTH-1:0] io_pins_writeEnable,
  gpio_bank_if.slave       io_bus,
  output logic             io_irq
);

  localparam logic [15:0] DEBOUNCE_CNT = 16'(DEBOUNCE);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] syncReg;
  logic [WIDTH-1:0] syncOut;
  logic [WIDTH-1:0] inQ;
  logic [WIDTH-1:0] inChange;
  logic [WIDTH-1:0] outReg;
  logic [WIDTH-1:0] oeReg;
  logic [WIDTH-1:0] riseEnReg;
  logic [WIDTH-1:0] fallEnReg;
  logic [WIDTH-1:0] pendingReg;
  logic [WIDTH-1:0] rdataReg;
  logic [WIDTH-1:0] readMux;
  logic [WIDTH-1:0] w1cMask;
  logic [WIDTH-1:0] riseEvt;
  logic [WIDTH-1:0] fallEvt;
  logic             readyReg;
  logic             heldReg;
  logic             accept;
  logic             wrAccept;

  always_ff @(posedge io_clock) begin
    if (!io_resetn) begin
      syncReg <= '0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], io_pins_read};
    end
  end

  assign syncOut = syncReg[SYNC_STAGES-1];

  // Per-pin filter: a change is accepted only after DEBOUNCE+1 consecutive mismatching cycles.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
      logic [15:0] cntReg;
      logic        qReg;
      logic        change;

      assign change = (syncOut[gi] != qReg) && (cntReg == DEBOUNCE_CNT);

      always_ff @(posedge io_clock) begin
        if (!io_resetn) begin
          cntReg <= '0;
          qReg   <= 1'b0;
        end else if (syncOut[gi] == qReg) begin
          cntReg <= '0;
        end else if (change) begin
          qReg   <= syncOut[gi];
          cntReg <= '0;
        end else begin
          cntReg <= cntReg + 16'd1;
        end
      end

      assign inQ[gi]      = qReg;
      assign inChange[gi] = change;
    end
  endgenerate

  assign riseEvt = inChange &  syncOut & riseEnReg;
  assign fallEvt = inChange & ~syncOut & fallEnReg;

  // heldReg blocks re-acceptance while the same request is still held after its ready pulse.
  assign accept   = io_bus.valid && !readyReg && !heldReg;
  assign wrAccept = accept && io_bus.write;
  assign w1cMask  = (wrAccept && io_bus.addr == 3'd5) ? io_bus.wdata : '0;

  always_comb begin
    readMux = '0;
    case (io_bus.addr)
      3'd0:    readMux = inQ;
      3'd1:    readMux = outReg;
      3'd2:    readMux = oeReg;
      3'd3:    readMux = riseEnReg;
      3'd4:    readMux = fallEnReg;
      3'd5:    readMux = pendingReg;
      default: readMux = '0;
    endcase
  end

  always_ff @(posedge io_clock) begin
    if (!io_resetn) begin
      outReg     <= '0;
      oeReg      <= '0;
      riseEnReg  <= '0;
      fallEnReg  <= '0;
      pendingReg <= '0;
      readyReg   <= 1'b0;
      rdataReg   <= '0;
      heldReg    <= 1'b0;
    end else begin
      readyReg   <= accept;
      rdataReg   <= (accept && !io_bus.write) ? readMux : '0;
      heldReg    <= io_bus.valid && (heldReg || accept);
      // A new event on the same edge as its W1C keeps the bit set.
      pendingReg <= (pendingReg & ~w1cMask) | riseEvt | fallEvt;
      if (wrAccept) begin
        case (io_bus.addr)
          3'd1:    outReg    <= io_bus.wdata;
          3'd2:    oeReg     <= io_bus.wdata;
          3'd3:    riseEnReg <= io_bus.wdata;
          3'd4:    fallEnReg <= io_bus.wdata;
          3'd6:    outReg    <= outReg | io_bus.wdata;
          3'd7:    outReg    <= outReg & ~io_bus.wdata;
          default: ;
        endcase
      end
    end
  end

  assign io_bus.ready        = readyReg;
  assign io_bus.rdata        = rdataReg;
  assign io_pins_write       = outReg;
  assign io_pins_writeEnable = oeReg;
  assign io_irq              = |pendingReg;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: default instance plus a DEBOUNCE=4 instance,
// directed scenarios followed by randomised register and pin traffic against a model.
module tb_gpio_bank;

  logic       clk;
  logic       resetn;
  logic [2:0] pinsA, pinsB;
  logic [2:0] wA, oeA, wB, oeB;
  logic       irqA, irqB;

  int vectors;
  int miscompares;

  // reference model of unit A's software-visible registers
  logic [2:0] outM, oeM, riseM, fallM, pendM;

  gpio_bank_if #(.WIDTH(3)) busA ();
  gpio_bank_if #(.WIDTH(3)) busB ();

  gpio_bank #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE(0)) dutA (
    .io_clock(clk), .io_resetn(resetn), .io_pins_read(pinsA),
    .io_pins_write(wA), .io_pins_writeEnable(oeA), .io_bus(busA), .io_irq(irqA)
  );

  gpio_bank #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE(4)) dutB (
    .io_clock(clk), .io_resetn(resetn), .io_pins_read(pinsB),
    .io_pins_write(wB), .io_pins_writeEnable(oeB), .io_bus(busB), .io_irq(irqB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic busOp(input int unit, input bit wr, input logic [2:0] addr,
                       input logic [2:0] wd, output logic [2:0] rd);
    bit got;
    got = 1'b0;
    rd  = 'x;
    @(posedge clk); #1;
    if (unit == 0) begin
      busA.valid = 1'b1; busA.write = wr; busA.addr = addr; busA.wdata = wd;
    end else begin
      busB.valid = 1'b1; busB.write = wr; busB.addr = addr; busB.wdata = wd;
    end
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      if (unit == 0 && busA.ready === 1'b1) begin got = 1'b1; rd = busA.rdata; end
      if (unit != 0 && busB.ready === 1'b1) begin got = 1'b1; rd = busB.rdata; end
    end
    busA.valid = 1'b0;
    busB.valid = 1'b0;
    $display("bus unit=%0d %s addr=%0d wdata=%b rdata=%b", unit, wr ? "wr" : "rd", addr, wd, rd);
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL bus_timeout unit=%0d addr=%0d got no ready, required ready within 8 cycles", unit, addr);
    end
  endtask

  task automatic test_reset();
    logic [2:0] rd;
    resetn = 1'b0; pinsA = 3'b111; pinsB = 3'b000;
    repeat (2) @(posedge clk); #1;
    vectors++; if (wA !== 3'b000) begin miscompares++; $display("FAIL reset_write got=%b exp=000", wA); end
    vectors++; if (oeA !== 3'b000) begin miscompares++; $display("FAIL reset_oe got=%b exp=000", oeA); end
    vectors++; if (busA.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", busA.ready); end
    vectors++; if (busA.rdata !== 3'b000) begin miscompares++; $display("FAIL reset_rdata got=%b exp=000", busA.rdata); end
    vectors++; if (irqA !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%b exp=0", irqA); end
    resetn = 1'b1;
    repeat (3) @(posedge clk); #1;
    busOp(0, 1'b0, 3'd0, 3'b000, rd);
    vectors++; if (rd !== 3'b111) begin miscompares++; $display("FAIL reset_in got=%b exp=111", rd); end
    busOp(0, 1'b0, 3'd5, 3'b000, rd);
    vectors++; if (rd !== 3'b000) begin miscompares++; $display("FAIL reset_pending got=%b exp=000", rd); end
    vectors++; if (irqA !== 1'b0) begin miscompares++; $display("FAIL reset_irq_after got=%b exp=0", irqA); end
    outM = '0; oeM = '0; riseM = '0; fallM = '0; pendM = '0;
  endtask

  task automatic test_output_path();
    logic [2:0] rd;
    busOp(0, 1'b1, 3'd2, 3'b101, rd); oeM = 3'b101;
    vectors++; if (oeA !== 3'b101) begin miscompares++; $display("FAIL oe_write got=%b exp=101", oeA); end
    vectors++; if (rd !== 3'b000) begin miscompares++; $display("FAIL write_rdata got=%b exp=000", rd); end
    busOp(0, 1'b1, 3'd1, 3'b111, rd); outM = 3'b111;
    vectors++; if (wA !== 3'b111) begin miscompares++; $display("FAIL out_write got=%b exp=111", wA); end
    busOp(0, 1'b1, 3'd6, 3'b010, rd); outM = outM | 3'b010;
    vectors++; if (wA !== 3'b111) begin miscompares++; $display("FAIL out_set got=%b exp=111", wA); end
    busOp(0, 1'b1, 3'd7, 3'b001, rd); outM = outM & ~3'b001;
    vectors++; if (wA !== 3'b110) begin miscompares++; $display("FAIL out_clr got=%b exp=110", wA); end
    busOp(0, 1'b0, 3'd6, 3'b000, rd);
    vectors++; if (rd !== 3'b000) begin miscompares++; $display("FAIL read_set got=%b exp=000", rd); end
    busOp(0, 1'b0, 3'd7, 3'b000, rd);
    vectors++; if (rd !== 3'b000) begin miscompares++; $display("FAIL read_clr got=%b exp=000", rd); end
    busOp(0, 1'b0, 3'd1, 3'b000, rd);
    vectors++; if (rd !== outM) begin miscompares++; $display("FAIL read_out got=%b exp=%b", rd, outM); end
    vectors++; if (oeA !== oeM) begin miscompares++; $display("FAIL oe_hold got=%b exp=%b", oeA, oeM); end
  endtask

  task automatic test_edge_irq();
    logic [2:0] rd;
    pinsA = 3'b000;
    repeat (5) @(posedge clk); #1;
    vectors++; if (irqA !== 1'b0) begin miscompares++; $display("FAIL fall_disabled_irq got=%b exp=0", irqA); end
    busOp(0, 1'b1, 3'd3, 3'b001, rd); riseM = 3'b001;
    busOp(0, 1'b1, 3'd4, 3'b000, rd); fallM = 3'b000;
    pinsA = 3'b001;
    repeat (2) @(posedge clk); #1;
    vectors++; if (irqA !== 1'b0) begin miscompares++; $display("FAIL irq_early got=%b exp=0", irqA); end
    @(posedge clk); #1;
    vectors++; if (irqA !== 1'b1) begin miscompares++; $display("FAIL irq_edge3 got=%b exp=1", irqA); end
    busOp(0, 1'b0, 3'd5, 3'b000, rd);
    vectors++; if (rd !== 3'b001) begin miscompares++; $display("FAIL pending_rise got=%b exp=001", rd); end
    busOp(0, 1'b1, 3'd5, 3'b001, rd);
    vectors++; if (irqA !== 1'b0) begin miscompares++; $display("FAIL w1c_irq got=%b exp=0", irqA); end
    pinsA = 3'b000;
    repeat (5) @(posedge clk); #1;
    busOp(0, 1'b0, 3'd5, 3'b000, rd);
    vectors++; if (rd !== 3'b000) begin miscompares++; $display("FAIL fall_disabled_pending got=%b exp=000", rd); end
  endtask

  task automatic test_debounce();
    logic [2:0] rd;
    busOp(1, 1'b1, 3'd3, 3'b010, rd);
    pinsB = 3'b010;
    repeat (3) @(posedge clk); #1;
    pinsB = 3'b000;
    repeat (10) @(posedge clk); #1;
    vectors++; if (irqB !== 1'b0) begin miscompares++; $display("FAIL glitch_irq got=%b exp=0", irqB); end
    busOp(1, 1'b0, 3'd0, 3'b000, rd);
    vectors++; if (rd !== 3'b000) begin miscompares++; $display("FAIL glitch_in got=%b exp=000", rd); end
    pinsB = 3'b010;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        vectors++; if (irqB !== 1'b0) begin miscompares++; $display("FAIL debounce_edge6 got=%b exp=0", irqB); end
      end
      if (k == 7) begin
        vectors++; if (irqB !== 1'b1) begin miscompares++; $display("FAIL debounce_edge7 got=%b exp=1", irqB); end
      end
    end
    busOp(1, 1'b0, 3'd0, 3'b000, rd);
    vectors++; if (rd !== 3'b010) begin miscompares++; $display("FAIL debounce_in got=%b exp=010", rd); end
    @(posedge clk); #1;
    pinsB = 3'b000;
    repeat (12) @(posedge clk); #1;
    busOp(1, 1'b1, 3'd5, 3'b111, rd);
    vectors++; if (irqB !== 1'b0) begin miscompares++; $display("FAIL debounce_clear got=%b exp=0", irqB); end
  endtask

  task automatic test_collision();
    logic [2:0] rd;
    busOp(0, 1'b1, 3'd3, 3'b100, rd); riseM = 3'b100;
    busOp(0, 1'b1, 3'd4, 3'b100, rd); fallM = 3'b100;
    pinsA = 3'b100;
    repeat (5) @(posedge clk); #1;
    vectors++; if (irqA !== 1'b1) begin miscompares++; $display("FAIL collision_setup got=%b exp=1", irqA); end
    pinsA = 3'b000;
    repeat (2) @(posedge clk); #1;
    busA.valid = 1'b1; busA.write = 1'b1; busA.addr = 3'd5; busA.wdata = 3'b100;
    @(posedge clk); #1;
    vectors++; if (busA.ready !== 1'b1) begin miscompares++; $display("FAIL collision_accept got=%b exp=1", busA.ready); end
    busA.valid = 1'b0;
    $display("bus unit=0 wr addr=5 wdata=100 (collides with fall event)");
    busOp(0, 1'b0, 3'd5, 3'b000, rd);
    vectors++; if (rd !== 3'b100) begin miscompares++; $display("FAIL collision_pending got=%b exp=100", rd); end
    busOp(0, 1'b1, 3'd5, 3'b100, rd);
    busOp(0, 1'b0, 3'd5, 3'b000, rd);
    vectors++; if (rd !== 3'b000) begin miscompares++; $display("FAIL collision_cleared got=%b exp=000", rd); end
  endtask

  task automatic test_handshake();
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    busA.valid = 1'b1; busA.write = 1'b0; busA.addr = 3'd2; busA.wdata = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (busA.ready === 1'b1) pulses++;
      if (k == 1) begin
        vectors++; if (busA.rdata !== oeM) begin miscompares++; $display("FAIL hold_rdata got=%b exp=%b", busA.rdata, oeM); end
      end
    end
    vectors++; if (pulses != 1) begin miscompares++; $display("FAIL hold_pulses got=%0d exp=1", pulses); end
    $display("bus unit=0 rd addr=2 held 4 cycles pulses=%0d", pulses);
    busA.valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busA.ready !== 1'b0) begin miscompares++; $display("FAIL drop_ready got=%b exp=0", busA.ready); end
    busA.valid = 1'b1;
    @(posedge clk); #1;
    vectors++; if (busA.ready !== 1'b1) begin miscompares++; $display("FAIL reassert_ready got=%b exp=1", busA.ready); end
    busA.valid = 1'b0;
    @(posedge clk); #1;
    busA.valid = 1'b1; busA.addr = 3'd1;
    @(posedge clk); #1;
    resetn = 1'b0; busA.valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busA.ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0", busA.ready); end
    busA.valid = 1'b1; busA.write = 1'b1; busA.addr = 3'd1; busA.wdata = 3'b111;
    @(posedge clk); #1;
    resetn = 1'b1; busA.valid = 1'b0;
    @(posedge clk); #1;
    $display("bus unit=0 wr addr=1 wdata=111 under reset (abandoned)");
    vectors++; if (wA !== 3'b000) begin miscompares++; $display("FAIL reset_abandon got=%b exp=000", wA); end
    vectors++; if (busA.ready !== 1'b0) begin miscompares++; $display("FAIL reset_abandon_ready got=%b exp=0", busA.ready); end
    outM = '0; oeM = '0; riseM = '0; fallM = '0; pendM = '0;
  endtask

  task automatic test_random_regs();
    logic [2:0] rd, wd, exp;
    logic [2:0] addr;
    bit wr;
    pinsA = 3'($urandom);
    repeat (5) @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      addr = 3'($urandom_range(0, 7));
      wr   = 1'($urandom_range(0, 1));
      wd   = 3'($urandom);
      case (addr)
        3'd0: exp = pinsA;
        3'd1: exp = outM;
        3'd2: exp = oeM;
        3'd3: exp = riseM;
        3'd4: exp = fallM;
        3'd5: exp = pendM;
        default: exp = 3'b000;
      endcase
      busOp(0, wr, addr, wd, rd);
      if (wr) begin
        case (addr)
          3'd1: outM = wd;
          3'd2: oeM = wd;
          3'd3: riseM = wd;
          3'd4: fallM = wd;
          3'd5: pendM = pendM & ~wd;
          3'd6: outM = outM | wd;
          3'd7: outM = outM & ~wd;
          default: ;
        endcase
        exp = 3'b000;
      end
      vectors++; if (rd !== exp) begin miscompares++; $display("FAIL rand_rdata addr=%0d wr=%0d got=%b exp=%b", addr, wr, rd, exp); end
      vectors++; if (wA !== outM || oeA !== oeM) begin miscompares++; $display("FAIL rand_pads got=%b/%b exp=%b/%b", wA, oeA, outM, oeM); end
    end
  endtask

  task automatic test_random_pins();
    logic [2:0] rd, cur, h0, h1, h2, h3;
    riseM = 3'($urandom);
    fallM = 3'($urandom);
    busOp(0, 1'b1, 3'd3, riseM, rd);
    busOp(0, 1'b1, 3'd4, fallM, rd);
    busOp(0, 1'b1, 3'd5, 3'b111, rd);
    pendM = '0;
    cur = pinsA; h0 = cur; h1 = cur; h2 = cur; h3 = cur;
    for (int n = 0; n < 160; n++) begin
      if (n < 150 && $urandom_range(0, 2) == 0) cur = 3'($urandom);
      pinsA = cur;
      @(posedge clk); #1;
      h3 = h2; h2 = h1; h1 = h0; h0 = cur;
      // IN follows the pad two sampled edges later; pending collects its enabled edges
      pendM = pendM | (h2 & ~h3 & riseM) | (~h2 & h3 & fallM);
      vectors++; if (irqA !== (|pendM)) begin miscompares++; $display("FAIL rand_irq cycle=%0d got=%b exp=%b", n, irqA, |pendM); end
    end
    $display("pins run done riseEn=%b fallEn=%b final=%b", riseM, fallM, cur);
    busOp(0, 1'b0, 3'd5, 3'b000, rd);
    vectors++; if (rd !== pendM) begin miscompares++; $display("FAIL rand_pending got=%b exp=%b", rd, pendM); end
    busOp(0, 1'b0, 3'd0, 3'b000, rd);
    vectors++; if (rd !== cur) begin miscompares++; $display("FAIL rand_in got=%b exp=%b", rd, cur); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    busA.valid = 1'b0; busA.write = 1'b0; busA.addr = '0; busA.wdata = '0;
    busB.valid = 1'b0; busB.write = 1'b0; busB.addr = '0; busB.wdata = '0;
    resetn = 1'b0; pinsA = '0; pinsB = '0;
    outM = '0; oeM = '0; riseM = '0; fallM = '0; pendM = '0;
    @(posedge clk); #1;
    test_reset();
    test_output_path();
    test_edge_irq();
    test_debounce();
    test_collision();
    test_handshake();
    test_random_regs();
    test_random_pins();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
